// File: rtl/pwm_pkg.sv
// Shared types and default sizes for the multi-channel PWM block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pwm_pkg;

  typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTER = 1'b1} pwm_mode_t;
  typedef enum logic {CNT_UP = 1'b0, CNT_DOWN = 1'b1} cnt_dir_t;

  localparam int PWM_WIDTH_DEF  = 11;
  localparam int PWM_NUM_CH_DEF = 2;
  localparam int PWM_DT_W_DEF   = 6;

endpackage

// File: rtl/pwm_deadtime.sv
// Single-channel dead-time stage: raw PWM in, non-overlapping sig/sig_n out.
// Latency: 1 cycle from raw to sig/sig_n; both outputs drop on the edge after en falls.
// Backpressure: none; the turning-on side waits deadtime cycles of stable raw.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_W = PWM_DT_W_DEF
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            raw_vld,
  input  logic            raw,
  input  logic [DT_W-1:0] deadtime,
  output logic            sig,
  output logic            sig_n
);

  // One extra bit so that a stable count can exceed the largest deadtime.
  localparam int             K_W   = DT_W + 1;
  localparam logic [K_W-1:0] K_MAX = '1;
  localparam logic [K_W-1:0] K_ONE = {{(K_W-1){1'b0}}, 1'b1};

  logic           run;
  logic           run_q;
  logic           raw_q;
  logic [K_W-1:0] k_q;
  logic [K_W-1:0] k_nxt;
  logic           on_ok;

  assign run = en & raw_vld;

  // Count how many cycles raw has held its current level (1 on any change or restart).
  always_comb begin
    k_nxt = '0;
    if (run) begin
      if (run_q && (raw == raw_q)) begin
        k_nxt = (k_q == K_MAX) ? k_q : k_q + K_ONE;
      end else begin
        k_nxt = K_ONE;
      end
    end
  end

  // The side turning on may assert only once raw has been stable longer than deadtime.
  assign on_ok = (k_nxt > {1'b0, deadtime});

  // Register the stable count and the gated outputs; turning-off side drops at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      raw_q <= 1'b0;
      k_q   <= '0;
      sig   <= 1'b0;
      sig_n <= 1'b0;
    end else begin
      run_q <= run;
      raw_q <= raw;
      k_q   <= k_nxt;
      sig   <= run &  raw & on_ok;
      sig_n <= run & ~raw & on_ok;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM, shared edge/center counter, double-buffered duty; optional PWM_DEADTIME_EN.
// Latency: 1 cycle cnt -> PWM_sig/period_start (2 cycles with PWM_DEADTIME_EN).
// Backpressure: none; duty_vld always accepted, last write wins, applied at cnt==0.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH  = PWM_WIDTH_DEF,
  parameter int NUM_CH = PWM_NUM_CH_DEF,
  parameter int DT_W   = PWM_DT_W_DEF
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    center_mode,
  input  logic [NUM_CH*WIDTH-1:0] duty,
  input  logic                    duty_vld,
  input  logic [DT_W-1:0]         deadtime,
  output logic                    period_start,
  output logic [NUM_CH-1:0]       PWM_sig,
  output logic [NUM_CH-1:0]       PWM_sig_n
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]  cnt;
  logic [WIDTH-1:0]  cnt_nxt;
  cnt_dir_t          dir;
  cnt_dir_t          dir_nxt;
  pwm_mode_t         mode_act;
  logic              load;
  logic [WIDTH-1:0]  duty_sh  [NUM_CH];
  logic [WIDTH-1:0]  duty_act [NUM_CH];
  logic [NUM_CH-1:0] raw;
  logic              raw_vld;
  logic              ps_raw;

  // Next counter value: sawtooth in edge mode, 0..MAX..1 triangle in center mode.
  always_comb begin
    cnt_nxt = '0;
    dir_nxt = CNT_UP;
    if (en) begin
      if (mode_act == PWM_EDGE) begin
        cnt_nxt = cnt + ONE;
        dir_nxt = CNT_UP;
      end else if (cnt == MAX) begin
        cnt_nxt = cnt - ONE;
        dir_nxt = CNT_DOWN;
      end else if (cnt == '0) begin
        cnt_nxt = ONE;
        dir_nxt = CNT_UP;
      end else if (dir == CNT_DOWN) begin
        cnt_nxt = cnt - ONE;
        dir_nxt = CNT_DOWN;
      end else begin
        cnt_nxt = cnt + ONE;
        dir_nxt = CNT_UP;
      end
    end
  end

  // Active settings reload on the edge entering cnt==0, and every cycle while disabled.
  assign load = ~en | (cnt_nxt == '0);

  // Counter, direction and latched mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      dir      <= CNT_UP;
      mode_act <= PWM_EDGE;
    end else begin
      cnt <= cnt_nxt;
      dir <= dir_nxt;
      if (load) begin
        mode_act <= pwm_mode_t'(center_mode);
      end
    end
  end

  // Shadow duty takes every write; active duty takes the pre-write shadow at the boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        duty_sh[i]  <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (duty_vld) begin
          duty_sh[i] <= duty[i*WIDTH +: WIDTH];
        end
        if (load) begin
          duty_act[i] <= duty_sh[i];
        end
      end
    end
  end

  // Registered compare; raw_vld marks cycles whose raw came from a running counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw     <= '0;
      raw_vld <= 1'b0;
      ps_raw  <= 1'b0;
    end else begin
      raw_vld <= en;
      ps_raw  <= en & (cnt == '0);
      for (int i = 0; i < NUM_CH; i++) begin
        raw[i] <= en & (cnt < duty_act[i]);
      end
    end
  end

`ifdef PWM_DEADTIME_EN
  logic [DT_W-1:0] dt_sh;
  logic [DT_W-1:0] dt_act;

  // Dead-time is double-buffered alongside duty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dt_sh  <= '0;
      dt_act <= '0;
    end else begin
      if (duty_vld) begin
        dt_sh <= deadtime;
      end
      if (load) begin
        dt_act <= dt_sh;
      end
    end
  end

  // Delay period_start by the dead-time stage so it stays aligned with the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_start <= 1'b0;
    end else begin
      period_start <= en & ps_raw;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_dt
    pwm_deadtime #(
      .DT_W (DT_W)
    ) u_dt (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .raw_vld  (raw_vld),
      .raw      (raw[g]),
      .deadtime (dt_act),
      .sig      (PWM_sig[g]),
      .sig_n    (PWM_sig_n[g])
    );
  end
`else
  // Dead-time input has no function in this build.
  logic unused_dt;
  assign unused_dt = ^deadtime;

  assign PWM_sig      = raw;
  assign PWM_sig_n    = {NUM_CH{raw_vld}} & ~raw;
  assign period_start = ps_raw;
`endif

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi at WIDTH=4, NUM_CH=2; expected waveforms are queued per period.
// Latency: outputs compared 1 ns after each rising edge.
// Backpressure: n/a.
module tb_pwm_multi;

  localparam int WIDTH  = 4;
  localparam int NUM_CH = 2;
  localparam int DT_W   = 6;
  localparam int MAXV   = 15;
`ifdef PWM_DEADTIME_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    en;
  logic                    center_mode;
  logic [NUM_CH*WIDTH-1:0] duty;
  logic                    duty_vld;
  logic [DT_W-1:0]         deadtime;
  logic                    period_start;
  logic [NUM_CH-1:0]       PWM_sig;
  logic [NUM_CH-1:0]       PWM_sig_n;

  // Packed observation: {sig[1], sig[0], sig_n[1], sig_n[0], period_start}
  logic [4:0] exp_q[$];
  logic [4:0] got;
  logic [4:0] want;
  int         passed = 0;
  int         total  = 0;

  // Reference model state for the dead-time filter (deadtime 0 gives raw directly).
  int   m_k [2];
  logic m_prev [2];
  bit   m_fresh;
  int   m_dt;

  pwm_multi #(
    .WIDTH  (WIDTH),
    .NUM_CH (NUM_CH),
    .DT_W   (DT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .center_mode  (center_mode),
    .duty         (duty),
    .duty_vld     (duty_vld),
    .deadtime     (deadtime),
    .period_start (period_start),
    .PWM_sig      (PWM_sig),
    .PWM_sig_n    (PWM_sig_n)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Complementary outputs must never overlap.
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if ((PWM_sig & PWM_sig_n) !== 2'b00)
        $display("FAIL overlap: sig=%b sig_n=%b, required no common 1", PWM_sig, PWM_sig_n);
      else
        passed++;
    end
  end

  // Queue one full period of expected outputs from the counter shape and duties.
  task automatic push_period(input bit center, input logic [3:0] d0, input logic [3:0] d1);
    int p;
    p = center ? 2 * MAXV : MAXV + 1;
    for (int k = 0; k < p; k++) begin
      int         c;
      logic [1:0] s;
      logic [1:0] sn;
      logic       r;
      c = (center && k > MAXV) ? 2 * MAXV - k : k;
      for (int i = 0; i < 2; i++) begin
        r = (c < int'(i == 0 ? d0 : d1));
        if (m_fresh || r != m_prev[i]) m_k[i] = 1;
        else if (m_k[i] < 1000) m_k[i]++;
        m_prev[i] = r;
        s[i]  = r  && (m_k[i] > m_dt);
        sn[i] = !r && (m_k[i] > m_dt);
      end
      m_fresh = 1'b0;
      exp_q.push_back({s, sn, (k == 0)});
    end
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(5'b00000);
  endtask

  // Advance one clock, release any one-cycle write, and pop the expected word.
  task automatic step_pop();
    @(posedge clk);
    #1;
    duty_vld = 1'b0;
    got = {PWM_sig, PWM_sig_n, period_start};
    if (exp_q.size() > 0) want = exp_q.pop_front();
    else want = 5'bxxxxx;
  endtask

  // Load settings while disabled, then enable; the next step_pop shows phase 0.
  task automatic start(input bit center, input logic [3:0] d0, input logic [3:0] d1,
                       input int dt);
    en          = 1'b0;
    center_mode = center;
    duty        = {d1, d0};
    deadtime    = dt[DT_W-1:0];
    duty_vld    = 1'b1;
    @(posedge clk); #1;
    duty_vld = 1'b0;
    @(posedge clk); #1;
    en      = 1'b1;
    m_fresh = 1'b1;
`ifdef PWM_DEADTIME_EN
    m_dt = dt;
`else
    m_dt = 0;
`endif
    repeat (LAT - 1) begin @(posedge clk); #1; end
    exp_q.delete();
  endtask

  task automatic test_reset();
    en = 1'b0; center_mode = 1'b0; duty = '0; duty_vld = 1'b0; deadtime = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({PWM_sig, PWM_sig_n, period_start} !== 5'b00000)
      $display("FAIL reset_state: got %b required 00000", {PWM_sig, PWM_sig_n, period_start});
    else passed++;
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_edge();
    start(1'b0, 4'd5, 4'd10, 0);
    push_period(1'b0, 4'd5, 4'd10);
    push_period(1'b0, 4'd5, 4'd10);
    for (int j = 0; j < 32; j++) begin
      step_pop(); total++;
      if (got !== want) $display("FAIL edge_d5 cyc %0d: got %b required %b", j, got, want);
      else passed++;
    end
  endtask

  task automatic test_center();
    start(1'b1, 4'd4, 4'd9, 0);
    push_period(1'b1, 4'd4, 4'd9);
    push_period(1'b1, 4'd4, 4'd9);
    for (int j = 0; j < 60; j++) begin
      step_pop(); total++;
      if (got !== want) $display("FAIL center_d4 cyc %0d: got %b required %b", j, got, want);
      else passed++;
    end
  endtask

  task automatic test_shadow_mid();
    start(1'b0, 4'd5, 4'd2, 0);
    push_period(1'b0, 4'd5, 4'd2);
    push_period(1'b0, 4'd3, 4'd2);
    for (int j = 0; j < 32; j++) begin
      if (j == 6) begin duty = {4'd2, 4'd3}; duty_vld = 1'b1; end
      step_pop(); total++;
      if (got !== want) $display("FAIL shadow_mid cyc %0d: got %b required %b", j, got, want);
      else passed++;
    end
  endtask

  task automatic test_shadow_boundary();
    start(1'b0, 4'd5, 4'd2, 0);
    push_period(1'b0, 4'd5, 4'd2);
    push_period(1'b0, 4'd5, 4'd2);
    push_period(1'b0, 4'd3, 4'd2);
    for (int j = 0; j < 48; j++) begin
      // Write lands on the edge where the counter returns to 0.
      if (j == 16 - LAT) begin duty = {4'd2, 4'd3}; duty_vld = 1'b1; end
      step_pop(); total++;
      if (got !== want) $display("FAIL shadow_boundary cyc %0d: got %b required %b", j, got, want);
      else passed++;
    end
  endtask

  task automatic test_duty_limits();
    start(1'b0, 4'd0, 4'd15, 0);
    push_period(1'b0, 4'd0, 4'd15);
    push_period(1'b0, 4'd0, 4'd15);
    for (int j = 0; j < 32; j++) begin
      step_pop(); total++;
      if (got !== want) $display("FAIL duty_0_15 cyc %0d: got %b required %b", j, got, want);
      else passed++;
    end
  endtask

  task automatic test_mode_toggle();
    start(1'b0, 4'd5, 4'd3, 0);
    push_period(1'b0, 4'd5, 4'd3);
    push_period(1'b1, 4'd5, 4'd3);
    for (int j = 0; j < 46; j++) begin
      if (j == 8) center_mode = 1'b1;
      step_pop(); total++;
      if (got !== want) $display("FAIL mode_toggle cyc %0d: got %b required %b", j, got, want);
      else passed++;
    end
  endtask

  task automatic test_disable();
    start(1'b0, 4'd5, 4'd3, 0);
    push_period(1'b0, 4'd5, 4'd3);
    for (int j = 0; j < 3; j++) begin
      step_pop(); total++;
      if (got !== want) $display("FAIL pre_disable cyc %0d: got %b required %b", j, got, want);
      else passed++;
    end
    en = 1'b0;
    exp_q.delete();
    push_idle(2);
    for (int j = 0; j < 2; j++) begin
      step_pop(); total++;
      if (got !== want) $display("FAIL disabled cyc %0d: got %b required %b", j, got, want);
      else passed++;
    end
    // Restart must begin a fresh period from cnt==0.
    en = 1'b1;
    m_fresh = 1'b1;
    repeat (LAT - 1) begin @(posedge clk); #1; end
    push_period(1'b0, 4'd5, 4'd3);
    for (int j = 0; j < 16; j++) begin
      step_pop(); total++;
      if (got !== want) $display("FAIL reenable cyc %0d: got %b required %b", j, got, want);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    start(1'b0, 4'd5, 4'd3, 0);
    push_period(1'b0, 4'd5, 4'd3);
    for (int j = 0; j < 2; j++) begin
      step_pop(); total++;
      if (got !== want) $display("FAIL pre_reset cyc %0d: got %b required %b", j, got, want);
      else passed++;
    end
    #3 rst = 1'b1;
    #1;
    total++;
    if ({PWM_sig, PWM_sig_n, period_start} !== 5'b00000)
      $display("FAIL async_reset: got %b required 00000", {PWM_sig, PWM_sig_n, period_start});
    else passed++;
    en = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
  endtask

`ifdef PWM_DEADTIME_EN
  task automatic test_deadtime();
    int highs0;
    int highs1;
    start(1'b0, 4'd5, 4'd1, 2);
    push_period(1'b0, 4'd5, 4'd1);
    push_period(1'b0, 4'd5, 4'd1);
    highs0 = 0;
    highs1 = 0;
    for (int j = 0; j < 32; j++) begin
      step_pop(); total++;
      if (got !== want) $display("FAIL deadtime2 cyc %0d: got %b required %b", j, got, want);
      else passed++;
      if (j >= 16) begin
        highs0 += int'(got[3]);
        highs1 += int'(got[4]);
      end
    end
    total++;
    if (highs0 != 3) $display("FAIL deadtime_d5_width: got %0d high cycles required 3", highs0);
    else passed++;
    total++;
    if (highs1 != 0) $display("FAIL deadtime_d1_swallow: got %0d high cycles required 0", highs1);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_edge();
    test_center();
    test_shadow_mid();
    test_shadow_boundary();
    test_duty_limits();
    test_mode_toggle();
    test_disable();
    test_async_reset();
`ifdef PWM_DEADTIME_EN
    test_deadtime();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Parametrised multi-channel PWM generator. Replaces the single-channel fixed 11-bit PWM in the motion path. Shared WIDTH-bit counter supports edge-aligned (sawtooth) and center-aligned (triangle) modes. Per-channel duty is double-buffered and updates only at a period boundary, so outputs never glitch. Complementary outputs drive the H-bridge gate logic.

Parameters:
WIDTH, 11, counter/duty width; MAX = 2^WIDTH-1
NUM_CH, 2, number of independent channels sharing the counter
DT_W, 6, dead-time counter width (used only with PWM_DEADTIME_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  run enable
center_mode  in  1  0 = edge-aligned, 1 = center-aligned; latched at period boundary
duty  in  NUM_CH*WIDTH  packed duty words, ch0 in LSBs
duty_vld  in  1  write all duty words (and deadtime) into shadow registers this cycle
deadtime  in  DT_W  dead-time in clk cycles; ignored without PWM_DEADTIME_EN
period_start  out  1  one-cycle pulse aligned with output of the cnt==0 comparison
PWM_sig  out  NUM_CH  high-side PWM per channel
PWM_sig_n  out  NUM_CH  low-side (complementary) PWM per channel

Behaviour:
- Reset (async, rst=1): cnt=0, dir=up, shadow/active duty=0, mode_act=edge, PWM_sig=0, PWM_sig_n=0, period_start=0.
- Edge mode: cnt 0,1,…,MAX,0,… Period = 2^WIDTH cycles.
- Center mode: cnt 0,1,…,MAX,MAX-1,…,1,0,… Period = 2*MAX cycles. dir flips at cnt==MAX (to down) and cnt==0 (to up).
- Boundary: cnt==0. On the clock edge where cnt becomes 0, active duty <= shadow, mode_act <= center_mode, and active deadtime <= shadow deadtime. A mode change therefore takes effect only from cnt==0.
- Shadow write: duty_vld=1 captures duty/deadtime. Always accepted; last write wins.
  - No bypass: a write on the loading edge lands in the shadow, and active takes the pre-write shadow. The new value takes effect one period later.
- Raw compare per channel: raw[i] registered <= (cnt < duty_act[i]). Latency: 1 cycle from cnt to PWM_sig.
  - duty=0: never high.
  - Edge mode, duty=MAX: low only at cnt==MAX.
  - Center mode: high for 2*duty-1 cycles per period, centered on cnt==0 (duty≥1).
- Without dead-time: PWM_sig=raw, PWM_sig_n=~raw while running.
- period_start: registered, high for exactly the cycle whose outputs reflect cnt==0.
- en=0:
  - cnt forced to 0, dir=up.
  - PWM_sig=0 and PWM_sig_n=0 (both off, safe state) from the next edge.
  - period_start=0.
  - Active duty/mode track shadow every cycle.
- en 0→1: cnt starts at 0; first outputs one cycle later with period_start=1.
- Simultaneous duty_vld and en deassert: the write is kept.
- PWM_sig[i] and PWM_sig_n[i] are never both 1.

Optional Feature:
PWM_DEADTIME_EN. When defined, each channel adds a dead-time stage after raw. This adds 1 cycle latency, so period_start is delayed to stay aligned.
- The output that is turning off drops immediately on a raw transition.
- The output that is turning on asserts only after deadtime_act cycles, and only if raw is still in that state.
- For a raw pulse of L cycles: output active for max(L - deadtime, 0) cycles. Pulses of L ≤ deadtime are swallowed, with both outputs low.
- deadtime=0 is cycle-identical to the undefined case apart from the extra latency.
- When undefined: no dead-time logic, deadtime port unused, latency 1.

Decomposition:
- pwm_pkg:
  - typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_t
  - typedef enum logic {CNT_UP, CNT_DOWN} cnt_dir_t
  - default WIDTH/DT_W localparams
- Sub-module pwm_deadtime: single channel, raw in → sig/sig_n out. Instanced NUM_CH times inside a generate, only under PWM_DEADTIME_EN.

Test Plan:
- WIDTH=4, edge, duty0=5, en=1 → PWM_sig[0] high 5 / low 11; period_start every 16 cycles; PWM_sig_n[0] exact complement.
- WIDTH=4, center, duty0=4 → PWM_sig[0] high 7 of every 30 cycles, centered on the period_start cycle.
- Shadow timing:
  - duty0 written 5→3 mid-period → unchanged until the next period_start, then high 3.
  - Write on the cnt→0 edge → still 5 for that period, 3 the period after.
- Boundaries: duty=0 → PWM_sig=0, PWM_sig_n=1 constantly; edge duty=15 → PWM_sig low exactly 1 cycle per period; center_mode toggled mid-period → no change until the boundary.
- Disable and reset:
  - en dropped mid-pulse → next cycle both outputs 0, cnt=0.
  - rst asserted between clock edges → outputs 0 immediately, without waiting for clk.
- PWM_DEADTIME_EN, deadtime=2:
  - edge duty=5 → PWM_sig high 3 cycles, both low 2 cycles at each transition.
  - duty=1 → PWM_sig never high.
  - Assertion: sig&sig_n never 1.
